// File: rtl/voltmeter_pkg.sv
// rtl/voltmeter_pkg.sv - shared constants, FSM encoding and channel-number helpers
//
// Purpose: common definitions for the voltmeter text formatter.
//   NCH_DEFAULT  default number of BCD voltage channels
//   LINE_BYTES   bytes per text line: 'C' tens units ':' d3 '.' d2 d1 d0 'V' CR LF
//   ASCII_*      fixed characters of the line format
//   state_t      formatter FSM encoding
//   ch_tens / ch_units  split a channel number 0..99 into decimal digits using
//                       compares and a multiply by a constant (no divider)
package voltmeter_pkg;

   localparam int NCH_DEFAULT = 13;
   localparam int LINE_BYTES  = 12;

   localparam logic [7:0] ASCII_C     = 8'h43;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_V     = 8'h56;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Tens digit: the largest t in 0..9 with n >= 10*t.
   function automatic logic [3:0] ch_tens(input logic [6:0] n);
      logic [3:0] t;
      t = 4'd0;
      for (int i = 1; i < 10; i++) begin
         if (n >= 7'(10 * i)) begin
            t = 4'(i);
         end
      end
      return t;
   endfunction

   function automatic logic [3:0] ch_units(input logic [6:0] n);
      return 4'(n - ({3'b000, ch_tens(n)} * 7'd10));
   endfunction

endpackage

// File: rtl/bcd_nibble_to_ascii.sv
// rtl/bcd_nibble_to_ascii.sv - one BCD digit to its ASCII character
//
// Purpose: maps a BCD nibble to its printable digit; codes 10..15 are not
//          valid BCD and print as '?' so a bad ADC word is visible in the text.
// Ports:
//   nibble  in   4  BCD digit
//   ascii   out  8  '0'..'9' for 0..9, '?' otherwise
module bcd_nibble_to_ascii
   import voltmeter_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble <= 4'd9) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end else begin
         ascii = ASCII_QMARK;
      end
   end

endmodule

// File: rtl/uart_frame_formatter.sv
// rtl/uart_frame_formatter.sv - periodic BCD channel snapshot serialised as ASCII lines
//
// Purpose: every FRAME_CYCLES clocks a frame request is raised (when enabled);
//          the formatter snapshots all channels and writes one 12-byte line per
//          channel into the UART TX FIFO, at most one byte every two cycles.
// Ports:
//   clk         in   1         system clock, posedge
//   rst_n       in   1         asynchronous active-low reset
//   enable      in   1         1 = accept frame requests at period wrap
//   ch_bcd      in   16*NCH    channel k at [16k+15:16k], digits d3.d2d1d0
//   tx_full     in   1         FIFO full, no write while high
//   w_data      out  8         ASCII byte, valid only with wr_uart (0 otherwise)
//   wr_uart     out  1         one-cycle FIFO write strobe
//   busy        out  1         high from snapshot until the last byte is written
//   frame_done  out  1         one-cycle pulse in the cycle after the final LF
module uart_frame_formatter
   import voltmeter_pkg::*;
#(
   parameter int NCH          = NCH_DEFAULT,
   parameter int FRAME_CYCLES = 32_500_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [16*NCH-1:0]   ch_bcd,
   input  logic                tx_full,
   output logic [7:0]          w_data,
   output logic                wr_uart,
   output logic                busy,
   output logic                frame_done
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
   localparam logic [3:0]    LAST_BYTE = 4'(LINE_BYTES - 1);
   localparam logic [PW-1:0] LAST_CNT  = PW'(FRAME_CYCLES - 1);

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   period_cnt;
   logic            pending;
   logic [15:0]     snap [NCH];
   logic [CW-1:0]   ch_idx;
   logic [3:0]      byte_idx;

   logic            wrap;
   logic            take;
   logic            last_byte;
   logic [15:0]     cur_word;
   logic [3:0]      nibble;
   logic [7:0]      nibble_ascii;
   logic [7:0]      byte_mux;

   assign wrap      = (period_cnt == LAST_CNT);
   assign take      = (state == ST_IDLE) && pending;
   assign last_byte = (byte_idx == LAST_BYTE) && (ch_idx == LAST_CH);
   assign cur_word  = snap[ch_idx];

   // Period counter free-runs regardless of enable so the request cadence
   // stays locked to reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
      end else if (wrap) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   // Single request flag: a new request at wrap wins over the IDLE consume,
   // so a request coinciding with frame start is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (wrap && enable) begin
         pending <= 1'b1;
      end else if (take) begin
         pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      wr_uart    = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy       = 1'b1;
            state_next = ST_EMIT;
         end
         ST_EMIT: begin
            busy = 1'b1;
            if (!tx_full) begin
               wr_uart    = 1'b1;
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            // The idle cycle lets tx_full reflect the write just made.
            if (last_byte) begin
               frame_done = 1'b1;
               state_next = ST_IDLE;
            end else begin
               busy       = 1'b1;
               state_next = ST_EMIT;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Snapshot and line/byte position. Indices advance in GAP so the byte
   // presented in EMIT is stable for the whole stalled interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_idx   <= '0;
         byte_idx <= '0;
         for (int k = 0; k < NCH; k++) begin
            snap[k] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               ch_idx   <= '0;
               byte_idx <= '0;
               for (int k = 0; k < NCH; k++) begin
                  snap[k] <= ch_bcd[16*k +: 16];
               end
            end
            ST_GAP: begin
               if (byte_idx == LAST_BYTE) begin
                  byte_idx <= '0;
                  if (ch_idx != LAST_CH) begin
                     ch_idx <= ch_idx + CW'(1);
                  end
               end else begin
                  byte_idx <= byte_idx + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Digit source for the current byte position.
   always_comb begin
      nibble = 4'd0;
      case (byte_idx)
         4'd1:    nibble = ch_tens(7'(ch_idx));
         4'd2:    nibble = ch_units(7'(ch_idx));
         4'd4:    nibble = cur_word[15:12];
         4'd6:    nibble = cur_word[11:8];
         4'd7:    nibble = cur_word[7:4];
         4'd8:    nibble = cur_word[3:0];
         default: nibble = 4'd0;
      endcase
   end

   bcd_nibble_to_ascii u_digit (
      .nibble (nibble),
      .ascii  (nibble_ascii)
   );

   always_comb begin
      byte_mux = 8'h00;
      case (byte_idx)
         4'd0:    byte_mux = ASCII_C;
         4'd1,
         4'd2,
         4'd4,
         4'd6,
         4'd7,
         4'd8:    byte_mux = nibble_ascii;
         4'd3:    byte_mux = ASCII_COLON;
         4'd5:    byte_mux = ASCII_DOT;
         4'd9:    byte_mux = ASCII_V;
         4'd10:   byte_mux = ASCII_CR;
         4'd11:   byte_mux = ASCII_LF;
         default: byte_mux = 8'h00;
      endcase
   end

   assign w_data = wr_uart ? byte_mux : 8'h00;

endmodule

// File: tb/tb_uart_frame_formatter.sv
// tb/tb_uart_frame_formatter.sv - scoreboard bench for uart_frame_formatter
module tb_uart_frame_formatter;

   localparam int NCH         = 13;
   localparam int FC          = 2000;
   localparam int FRAME_BYTES = 12 * NCH;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              tx_full;
   logic [16*NCH-1:0] ch_bcd;
   logic [7:0]        w_data;
   logic              wr_uart;
   logic              busy;
   logic              frame_done;

   uart_frame_formatter #(.NCH(NCH), .FRAME_CYCLES(FC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .ch_bcd     (ch_bcd),
      .tx_full    (tx_full),
      .w_data     (w_data),
      .wr_uart    (wr_uart),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         failed = 0;
   int         cyc = 0;
   logic [7:0] exp_q [$];
   int         start_q [$];
   int         frame_bytes = 0;
   int         total_strobes = 0;
   int         frames_done = 0;
   logic       prev_wr = 1'b0;
   logic [15:0] vals [NCH];

   logic [7:0] line0 [12] = '{8'h43, 8'h30, 8'h30, 8'h3A, 8'h31, 8'h2E,
                              8'h32, 8'h33, 8'h34, 8'h56, 8'h0D, 8'h0A};
   logic [7:0] line12 [12] = '{8'h43, 8'h31, 8'h32, 8'h3A, 8'h30, 8'h2E,
                               8'h3F, 8'h30, 8'h35, 8'h56, 8'h0D, 8'h0A};

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (!rst_n) begin
         frame_bytes = 0;
         prev_wr     = 1'b0;
      end else begin
         if (wr_uart) begin
            if (prev_wr) check("strobe_gap", 1, 0);
            if (tx_full) check("strobe_while_full", 1, 0);
            check("busy_during_strobe", busy, 1);
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected_strobe: got byte %0h, expected no write", w_data);
            end else begin
               check($sformatf("byte f%0d b%0d", frames_done, frame_bytes), w_data, exp_q.pop_front());
            end
            if (frame_bytes == 0) start_q.push_back(cyc);
            frame_bytes++;
            total_strobes++;
         end
         if (frame_done) begin
            check("frame_len", frame_bytes, FRAME_BYTES);
            check("busy_at_done", busy, 0);
            frames_done++;
            frame_bytes = 0;
         end
         prev_wr = wr_uart;
      end
   end

   function automatic logic [7:0] dig(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
   endfunction

   task automatic push_line(input int k, input logic [15:0] w);
      exp_q.push_back(8'h43);
      exp_q.push_back(8'(48 + k / 10));
      exp_q.push_back(8'(48 + k % 10));
      exp_q.push_back(8'h3A);
      exp_q.push_back(dig(w[15:12]));
      exp_q.push_back(8'h2E);
      exp_q.push_back(dig(w[11:8]));
      exp_q.push_back(dig(w[7:4]));
      exp_q.push_back(dig(w[3:0]));
      exp_q.push_back(8'h56);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic push_frame(input bit hand);
      for (int k = 0; k < NCH; k++) begin
         if (hand && k == 0) begin
            for (int b = 0; b < 12; b++) exp_q.push_back(line0[b]);
         end else if (hand && k == 12) begin
            for (int b = 0; b < 12; b++) exp_q.push_back(line12[b]);
         end else begin
            push_line(k, vals[k]);
         end
      end
   endtask

   task automatic apply_vals();
      for (int k = 0; k < NCH; k++) ch_bcd[16*k +: 16] = vals[k];
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (frames_done < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, frames_done >= target, 1);
   endtask

   task automatic wait_busy(input int budget, input string name);
      int n;
      n = 0;
      while (!busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel;
      int own;
      int guard;
      int s;
      int base;
      int fd;

      rst_n   = 1'b0;
      enable  = 1'b1;
      tx_full = 1'b0;
      ch_bcd  = '0;
      vals = '{16'h1234, 16'h0000, 16'h9876, 16'h5050, 16'hF000, 16'h0005, 16'h0060,
               16'h0700, 16'h8000, 16'h3141, 16'h2718, 16'h1618, 16'h0A05};
      apply_vals();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wr_uart", wr_uart, 0);
      check("rst_w_data", w_data, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);

      // Frame 1: unstalled, hand-computed line 0 and line 12
      push_frame(1);
      rst_n = 1'b1;
      rel   = cyc;
      wait_frames(1, FC + 600, "frame1_done");
      check("first_strobe_latency", (start_q.size() > 0) ? start_q[0] - rel : -1, FC + 2);
      check("frame1_strobes", total_strobes, FRAME_BYTES);

      // Frame 2: inputs change one cycle after LOAD, stall after line 3 byte 5
      push_frame(1);
      wait_busy(FC + 100, "frame2_load");
      @(negedge clk);
      for (int k = 0; k < NCH; k++) vals[k] = 16'h9999;
      apply_vals();
      own   = wr_uart ? 1 : 0;
      guard = 0;
      while (own < 42 && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (wr_uart) own++;
      end
      check("stall_point_reached", own, 42);
      @(posedge clk);
      #1 tx_full = 1'b1;
      s = total_strobes;
      repeat (100) @(posedge clk);
      #1;
      check("no_strobe_in_stall", total_strobes - s, 0);
      check("stall_frame_pos", frame_bytes, 42);
      check("busy_in_stall", busy, 1);
      tx_full = 1'b0;
      wait_frames(2, FC, "frame2_done");

      // Frame 3: all 9.999V; enable dropped mid-frame
      push_frame(0);
      wait_busy(FC + 100, "frame3_load");
      repeat (20) @(negedge clk);
      enable = 1'b0;
      wait_frames(3, FC, "frame3_done");
      s = total_strobes;
      repeat (2500) @(negedge clk);
      check("no_frame_when_disabled", total_strobes - s, 0);
      check("idle_when_disabled", busy, 0);

      // Stall across a wrap, then reset mid-frame
      enable  = 1'b1;
      tx_full = 1'b1;
      wait_busy(FC + 100, "frame4_load");
      s = total_strobes;
      repeat (2100) @(negedge clk);
      check("stalled_busy", busy, 1);
      check("stalled_no_strobe", total_strobes - s, 0);
      rst_n   = 1'b0;
      tx_full = 1'b0;
      #1;
      check("abort_wr_uart", wr_uart, 0);
      check("abort_w_data", w_data, 0);
      check("abort_busy", busy, 0);
      check("abort_frame_done", frame_done, 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < NCH; k++) vals[k] = {4'(k % 10), 4'h5, 4'(9 - k % 10), 4'h0};
      apply_vals();
      push_frame(0);
      push_frame(0);
      base  = start_q.size();
      fd    = frames_done;
      rst_n = 1'b1;
      rel   = cyc;
      wait_frames(fd + 2, 2 * FC + 700, "post_reset_frames");
      check("post_reset_latency", (start_q.size() > base) ? start_q[base] - rel : -1, FC + 2);
      check("frame_period", (start_q.size() > base + 1) ? start_q[base+1] - start_q[base] : -1, FC);
      check("post_reset_frame_count", frames_done - fd, 2);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
